// File: rtl/adc_sequencer_pkg.sv
// Shared types and widths for the ADC conversion sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package adc_sequencer_pkg;

    localparam int CHANNEL_WIDTH = 5;
    localparam int DATA_WIDTH    = 12;
    localparam int TMO_WIDTH     = 8;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Destination of the conversion result currently in flight.
    typedef enum logic [1:0] {
        TGT_AUDIO = 2'd0,
        TGT_AUX0  = 2'd1,
        TGT_AUX1  = 2'd2
    } target_e;

endpackage

// File: rtl/adc_sequencer_rate_divider.sv
// Free-running divider: one-cycle tick every DIVIDE clocks.
// Latency: first tick DIVIDE cycles after reset release, registered output.
// Backpressure: none, ticks are never held.
module adc_sequencer_rate_divider #(
    parameter int DIVIDE = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_out
);

    localparam int CW = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count wraps at DIVIDE-1; the tick is registered off the wrap.
    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_q == LAST);
    end

    // Counter and tick registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_out = tick_q;

endmodule

// File: rtl/adc_sequencer.sv
// Schedules ADC conversions: periodic audio channel interleaved with two aux channels.
// Latency: tick -> command valid in 2 cycles; response -> result strobe in 1 cycle.
// Backpressure: command held until command_ready_in; aux results held until ack; audio strobe has none.
module adc_sequencer
    import adc_sequencer_pkg::*;
#(
    parameter int AUDIO_DIVIDE = 1000,
    parameter int AUX_DIVIDE   = 100000,
    parameter int TIMEOUT      = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNEL_WIDTH-1:0] audio_channel_in,
    input  logic [CHANNEL_WIDTH-1:0] aux0_channel_in,
    input  logic [CHANNEL_WIDTH-1:0] aux1_channel_in,
    output logic                     command_valid_out,
    output logic [CHANNEL_WIDTH-1:0] command_channel_out,
    output logic                     command_startofpacket_out,
    output logic                     command_endofpacket_out,
    input  logic                     command_ready_in,
    input  logic                     response_valid_in,
    input  logic [CHANNEL_WIDTH-1:0] response_channel_in,
    input  logic [DATA_WIDTH-1:0]    response_data_in,
    output logic [DATA_WIDTH-1:0]    audio_out,
    output logic                     audio_stb_out,
    output logic [DATA_WIDTH-1:0]    aux0_out,
    output logic                     aux0_stb_out,
    input  logic                     aux0_ack_in,
    output logic [DATA_WIDTH-1:0]    aux1_out,
    output logic                     aux1_stb_out,
    input  logic                     aux1_ack_in,
    output logic                     overrun_out,
    output logic                     timeout_out,
    input  logic                     clear_errors_in
);

    localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(TIMEOUT);

    logic audio_tick, aux_tick;

    adc_sequencer_rate_divider #(.DIVIDE(AUDIO_DIVIDE)) u_audio_div (
        .clk      (clk),
        .rst      (rst),
        .tick_out (audio_tick)
    );

    adc_sequencer_rate_divider #(.DIVIDE(AUX_DIVIDE)) u_aux_div (
        .clk      (clk),
        .rst      (rst),
        .tick_out (aux_tick)
    );

    state_e                   state_q, state_d;
    target_e                  tgt_q, tgt_d;
    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
    logic                     cmd_vld_q, cmd_vld_d;
    logic [TMO_WIDTH-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                     audio_pend_q, audio_pend_d;
    logic                     aux0_pend_q, aux0_pend_d;
    logic                     aux1_pend_q, aux1_pend_d;
    logic [DATA_WIDTH-1:0]    audio_dat_q, audio_dat_d;
    logic                     audio_stb_q, audio_stb_d;
    logic [DATA_WIDTH-1:0]    aux0_dat_q, aux0_dat_d;
    logic                     aux0_stb_q, aux0_stb_d;
    logic [DATA_WIDTH-1:0]    aux1_dat_q, aux1_dat_d;
    logic                     aux1_stb_q, aux1_stb_d;
    logic                     overrun_q, overrun_d;
    logic                     timeout_q, timeout_d;

    logic issue_fire, resp_hit, tmo_hit;
    logic audio_issued, aux0_issued, aux1_issued;
    logic aux0_wr, aux1_wr;

    assign issue_fire   = (state_q == ST_ISSUE) && cmd_vld_q && command_ready_in;
    assign resp_hit     = (state_q == ST_WAIT) && response_valid_in && (response_channel_in == chan_q);
    assign tmo_hit      = (state_q == ST_WAIT) && !resp_hit && ((tmo_cnt_q + TMO_WIDTH'(1)) == TMO_LIMIT);
    assign audio_issued = issue_fire && (tgt_q == TGT_AUDIO);
    assign aux0_issued  = issue_fire && (tgt_q == TGT_AUX0);
    assign aux1_issued  = issue_fire && (tgt_q == TGT_AUX1);

    // Sequencer next state: arbitration, handshake, response capture, error flags.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        chan_d      = chan_q;
        cmd_vld_d   = cmd_vld_q;
        tmo_cnt_d   = tmo_cnt_q;
        audio_dat_d = audio_dat_q;
        audio_stb_d = 1'b0;
        aux0_dat_d  = aux0_dat_q;
        aux1_dat_d  = aux1_dat_q;
        aux0_wr     = 1'b0;
        aux1_wr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Fixed priority: the audio stream must not slip behind housekeeping.
                if (audio_pend_q) begin
                    chan_d    = audio_channel_in;
                    tgt_d     = TGT_AUDIO;
                    cmd_vld_d = 1'b1;
                    state_d   = ST_ISSUE;
                end else if (aux0_pend_q) begin
                    chan_d    = aux0_channel_in;
                    tgt_d     = TGT_AUX0;
                    cmd_vld_d = 1'b1;
                    state_d   = ST_ISSUE;
                end else if (aux1_pend_q) begin
                    chan_d    = aux1_channel_in;
                    tgt_d     = TGT_AUX1;
                    cmd_vld_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_fire) begin
                    cmd_vld_d = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (resp_hit) begin
                    state_d = ST_IDLE;
                    case (tgt_q)
                        TGT_AUDIO: begin
                            audio_dat_d = response_data_in;
                            audio_stb_d = 1'b1;
                        end
                        TGT_AUX0: begin
                            aux0_dat_d = response_data_in;
                            aux0_wr    = 1'b1;
                        end
                        default: begin
                            aux1_dat_d = response_data_in;
                            aux1_wr    = 1'b1;
                        end
                    endcase
                end else if (tmo_hit) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_WIDTH'(1);
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_WIDTH'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cmd_vld_d = 1'b0;
            end
        endcase

        // A write in the same cycle as an ack keeps the strobe up for the new value.
        aux0_stb_d = aux0_wr | (aux0_stb_q & ~aux0_ack_in);
        aux1_stb_d = aux1_wr | (aux1_stb_q & ~aux1_ack_in);

        audio_pend_d = (audio_pend_q & ~audio_issued) | audio_tick;
        aux0_pend_d  = (aux0_pend_q & ~aux0_issued) | aux_tick;
        aux1_pend_d  = (aux1_pend_q & ~aux1_issued) | aux_tick;

        // Set events take precedence over a simultaneous clear.
        overrun_d = (audio_tick & audio_pend_q & ~audio_issued) | (overrun_q & ~clear_errors_in);
        timeout_d = tmo_hit | (timeout_q & ~clear_errors_in);
    end

    // All sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tgt_q        <= TGT_AUDIO;
            chan_q       <= '0;
            cmd_vld_q    <= 1'b0;
            tmo_cnt_q    <= '0;
            audio_pend_q <= 1'b0;
            aux0_pend_q  <= 1'b0;
            aux1_pend_q  <= 1'b0;
            audio_dat_q  <= '0;
            audio_stb_q  <= 1'b0;
            aux0_dat_q   <= '0;
            aux0_stb_q   <= 1'b0;
            aux1_dat_q   <= '0;
            aux1_stb_q   <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            chan_q       <= chan_d;
            cmd_vld_q    <= cmd_vld_d;
            tmo_cnt_q    <= tmo_cnt_d;
            audio_pend_q <= audio_pend_d;
            aux0_pend_q  <= aux0_pend_d;
            aux1_pend_q  <= aux1_pend_d;
            audio_dat_q  <= audio_dat_d;
            audio_stb_q  <= audio_stb_d;
            aux0_dat_q   <= aux0_dat_d;
            aux0_stb_q   <= aux0_stb_d;
            aux1_dat_q   <= aux1_dat_d;
            aux1_stb_q   <= aux1_stb_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign command_valid_out         = cmd_vld_q;
    assign command_channel_out       = chan_q;
    assign command_startofpacket_out = cmd_vld_q;
    assign command_endofpacket_out   = cmd_vld_q;
    assign audio_out                 = audio_dat_q;
    assign audio_stb_out             = audio_stb_q;
    assign aux0_out                  = aux0_dat_q;
    assign aux0_stb_out              = aux0_stb_q;
    assign aux1_out                  = aux1_dat_q;
    assign aux1_stb_out              = aux1_stb_q;
    assign overrun_out               = overrun_q;
    assign timeout_out               = timeout_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer with an ADC core model and result scoreboard.
// Latency: n/a.
// Backpressure: bench drives command_ready_in and aux acks.
module tb_adc_sequencer;

    localparam int M_OFF    = 0;
    localparam int M_NORMAL = 1;
    localparam int M_SILENT = 2;
    localparam int M_WRONG  = 3;

    typedef struct {
        logic [11:0] dat;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [4:0] ch;
        int         cyc;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  audio_channel_in, aux0_channel_in, aux1_channel_in;
    logic        command_valid_out;
    logic [4:0]  command_channel_out;
    logic        command_startofpacket_out, command_endofpacket_out;
    logic        command_ready_in;
    logic        response_valid_in;
    logic [4:0]  response_channel_in;
    logic [11:0] response_data_in;
    logic [11:0] audio_out, aux0_out, aux1_out;
    logic        audio_stb_out, aux0_stb_out, aux1_stb_out;
    logic        aux0_ack_in, aux1_ack_in;
    logic        overrun_out, timeout_out, clear_errors_in;

    int tests = 0;
    int fails = 0;
    int rel_cyc = 0;
    int mode = M_NORMAL;

    exp_t audio_q[$];
    exp_t aux0_q[$];
    exp_t aux1_q[$];
    cmd_t cmd_q[$];

    adc_sequencer #(
        .AUDIO_DIVIDE (20),
        .AUX_DIVIDE   (40),
        .TIMEOUT      (16)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .audio_channel_in          (audio_channel_in),
        .aux0_channel_in           (aux0_channel_in),
        .aux1_channel_in           (aux1_channel_in),
        .command_valid_out         (command_valid_out),
        .command_channel_out       (command_channel_out),
        .command_startofpacket_out (command_startofpacket_out),
        .command_endofpacket_out   (command_endofpacket_out),
        .command_ready_in          (command_ready_in),
        .response_valid_in         (response_valid_in),
        .response_channel_in       (response_channel_in),
        .response_data_in          (response_data_in),
        .audio_out                 (audio_out),
        .audio_stb_out             (audio_stb_out),
        .aux0_out                  (aux0_out),
        .aux0_stb_out              (aux0_stb_out),
        .aux0_ack_in               (aux0_ack_in),
        .aux1_out                  (aux1_out),
        .aux1_stb_out              (aux1_stb_out),
        .aux1_ack_in               (aux1_ack_in),
        .overrun_out               (overrun_out),
        .timeout_out               (timeout_out),
        .clear_errors_in           (clear_errors_in)
    );

    always #5 clk = ~clk;

    // Clock edges since the last edge that sampled reset high.
    always @(posedge clk) begin
        if (rst) rel_cyc <= 0;
        else     rel_cyc <= rel_cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (rel cycle %0d)", tag, obs, want, rel_cyc);
        end
    endtask

    task automatic goto(input int n);
        int guard = 0;
        @(negedge clk);
        while (rel_cyc != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (rel_cyc != n) chk("goto_bound", rel_cyc, n);
    endtask

    task automatic do_reset(input int m, input logic rdy);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mode             = m;
        command_ready_in = rdy;
        clear_errors_in  = 1'b0;
        rst              = 1'b0;
    endtask

    task automatic drain(input string tag);
        command_ready_in = 1'b0;
        repeat (30) @(negedge clk);
        chk({tag, "_audio_left"}, audio_q.size(), 0);
        chk({tag, "_aux0_left"}, aux0_q.size(), 0);
        chk({tag, "_aux1_left"}, aux1_q.size(), 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, command_valid_out, 0);
        chk({tag, "_chan"}, command_channel_out, 0);
        chk({tag, "_sop"}, command_startofpacket_out, 0);
        chk({tag, "_audio"}, {audio_stb_out, audio_out}, 0);
        chk({tag, "_aux0"}, {aux0_stb_out, aux0_out}, 0);
        chk({tag, "_aux1"}, {aux1_stb_out, aux1_out}, 0);
        chk({tag, "_flags"}, {overrun_out, timeout_out}, 0);
    endtask

    // ADC core model plus result scoreboard and aux acknowledger.
    initial begin
        logic        resp_pend = 1'b0;
        int          resp_at = 0;
        logic [4:0]  resp_ch = '0;
        logic [11:0] resp_dat = '0;
        logic        wrong_sent = 1'b0;
        logic        prev0 = 1'b0, prev1 = 1'b0;
        int          cnt0 = 0, cnt1 = 0;
        exp_t        e;
        cmd_t        c;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                resp_pend = 1'b0;
                if (mode != M_OFF) response_valid_in = 1'b0;
                aux0_ack_in = 1'b0;
                aux1_ack_in = 1'b0;
                prev0 = 1'b0; prev1 = 1'b0; cnt0 = 0; cnt1 = 0;
                audio_q.delete(); aux0_q.delete(); aux1_q.delete(); cmd_q.delete();
            end else begin
                if (mode != M_OFF) begin
                    response_valid_in = 1'b0;
                    if (resp_pend && rel_cyc == resp_at) begin
                        if (mode == M_WRONG && !wrong_sent) begin
                            response_valid_in   = 1'b1;
                            response_channel_in = 5'd7;
                            response_data_in    = 12'hBAD;
                            wrong_sent          = 1'b1;
                            resp_at             = resp_at + 1;
                        end else begin
                            response_valid_in   = 1'b1;
                            response_channel_in = resp_ch;
                            response_data_in    = resp_dat;
                            e.dat = resp_dat;
                            e.cyc = rel_cyc + 1;
                            if (resp_ch == 5'd1)      audio_q.push_back(e);
                            else if (resp_ch == 5'd2) aux0_q.push_back(e);
                            else                      aux1_q.push_back(e);
                            resp_pend = 1'b0;
                        end
                    end
                end
                if (command_valid_out && command_ready_in) begin
                    c.ch  = command_channel_out;
                    c.cyc = rel_cyc;
                    cmd_q.push_back(c);
                    if (mode == M_NORMAL || mode == M_WRONG) begin
                        resp_pend  = 1'b1;
                        resp_at    = rel_cyc + 5;
                        resp_ch    = command_channel_out;
                        wrong_sent = 1'b0;
                        if (rel_cyc == 22 && command_channel_out == 5'd1)
                            resp_dat = (mode == M_WRONG) ? 12'h123 : 12'hA5C;
                        else
                            resp_dat = 12'($urandom_range(4095, 0));
                    end
                end

                if (audio_stb_out) begin
                    if (audio_q.size() == 0) chk("audio_unexpected_stb", audio_stb_out, 0);
                    else begin
                        e = audio_q.pop_front();
                        chk("audio_data", audio_out, e.dat);
                        chk("audio_stb_cycle", rel_cyc, e.cyc);
                    end
                end

                if (aux0_ack_in) begin
                    chk("aux0_stb_drop", aux0_stb_out, 0);
                    aux0_ack_in = 1'b0;
                end else if (cnt0 > 0) begin
                    chk("aux0_stb_hold", aux0_stb_out, 1);
                    cnt0--;
                    if (cnt0 == 0) aux0_ack_in = 1'b1;
                end
                if (aux0_stb_out && !prev0) begin
                    if (aux0_q.size() == 0) chk("aux0_unexpected_stb", aux0_stb_out, 0);
                    else begin
                        e = aux0_q.pop_front();
                        chk("aux0_data", aux0_out, e.dat);
                        chk("aux0_stb_cycle", rel_cyc, e.cyc);
                    end
                    cnt0 = 3;
                end
                prev0 = aux0_stb_out;

                if (aux1_ack_in) begin
                    chk("aux1_stb_drop", aux1_stb_out, 0);
                    aux1_ack_in = 1'b0;
                end else if (cnt1 > 0) begin
                    chk("aux1_stb_hold", aux1_stb_out, 1);
                    cnt1--;
                    if (cnt1 == 0) aux1_ack_in = 1'b1;
                end
                if (aux1_stb_out && !prev1) begin
                    if (aux1_q.size() == 0) chk("aux1_unexpected_stb", aux1_stb_out, 0);
                    else begin
                        e = aux1_q.pop_front();
                        chk("aux1_data", aux1_out, e.dat);
                        chk("aux1_stb_cycle", rel_cyc, e.cyc);
                    end
                    cnt1 = 3;
                end
                prev1 = aux1_stb_out;
            end
        end
    end

    // Directed phases.
    initial begin
        int exp_ch[4];
        int exp_cy[4];
        exp_ch = '{1, 1, 2, 3};
        exp_cy = '{22, 42, 49, 56};

        rst                 = 1'b1;
        audio_channel_in    = 5'd1;
        aux0_channel_in     = 5'd2;
        aux1_channel_in     = 5'd3;
        command_ready_in    = 1'b1;
        response_valid_in   = 1'b0;
        response_channel_in = '0;
        response_data_in    = '0;
        aux0_ack_in         = 1'b0;
        aux1_ack_in         = 1'b0;
        clear_errors_in     = 1'b0;
        mode                = M_NORMAL;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values.
        chk_quiet("reset");

        // Normal interleaving: first command 22 cycles after release, then audio/aux0/aux1 order.
        goto(21);
        chk("first_cmd_not_early", command_valid_out, 0);
        goto(22);
        chk("first_cmd_valid", command_valid_out, 1);
        chk("first_cmd_chan", command_channel_out, 1);
        goto(70);
        chk("cmd_count_ok", cmd_q.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            chk("cmd_order_chan", cmd_q[i].ch, exp_ch[i]);
            chk("cmd_order_cycle", cmd_q[i].cyc, exp_cy[i]);
        end
        goto(260);
        chk("normal_no_errors", {overrun_out, timeout_out}, 0);
        drain("normal");

        // Core never answers: timeout 16 cycles after WAIT entry, then next pending command.
        do_reset(M_SILENT, 1'b1);
        goto(38);
        chk("timeout_not_early", timeout_out, 0);
        goto(39);
        chk("timeout_set", timeout_out, 1);
        chk("timeout_fsm_idle", command_valid_out, 0);
        goto(42);
        chk("after_timeout_cmd_valid", command_valid_out, 1);
        chk("after_timeout_cmd_chan", command_channel_out, 1);
        goto(45);
        clear_errors_in = 1'b1;
        goto(46);
        clear_errors_in = 1'b0;
        chk("timeout_cleared", timeout_out, 0);
        goto(58);
        clear_errors_in = 1'b1;
        goto(59);
        clear_errors_in = 1'b0;
        chk("timeout_set_beats_clear", timeout_out, 1);
        goto(60);
        chk("timeout_sticky", timeout_out, 1);
        clear_errors_in = 1'b1;
        goto(61);
        clear_errors_in = 1'b0;
        chk("timeout_cleared_again", timeout_out, 0);

        // Ready held low: command stays stable, second tick flags overrun.
        do_reset(M_NORMAL, 1'b0);
        for (int c = 22; c < 50; c++) begin
            goto(c);
            chk("stall_valid", command_valid_out, 1);
            chk("stall_chan", command_channel_out, 1);
            chk("stall_sop_eop", {command_startofpacket_out, command_endofpacket_out}, 2'b11);
            if (c == 40) chk("overrun_not_early", overrun_out, 0);
            if (c == 41) chk("overrun_set", overrun_out, 1);
        end
        goto(50);
        command_ready_in = 1'b1;
        goto(90);
        chk("overrun_sticky", overrun_out, 1);
        clear_errors_in = 1'b1;
        goto(91);
        clear_errors_in = 1'b0;
        chk("overrun_cleared", overrun_out, 0);
        goto(110);
        drain("stall");

        // Wrong-channel response ignored, correct one captured.
        do_reset(M_WRONG, 1'b1);
        goto(28);
        chk("wrong_chan_no_stb", audio_stb_out, 0);
        chk("wrong_chan_no_data", audio_out, 0);
        goto(29);
        chk("right_chan_stb", audio_stb_out, 1);
        chk("right_chan_data", audio_out, 12'h123);
        goto(32);
        drain("wrong");

        // Reset in WAIT with a response arriving just after.
        do_reset(M_OFF, 1'b1);
        goto(24);
        chk("waiting_no_valid", command_valid_out, 0);
        goto(25);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("midreset");
        rst                 = 1'b0;
        response_valid_in   = 1'b1;
        response_channel_in = 5'd1;
        response_data_in    = 12'hFFF;
        @(negedge clk);
        response_valid_in = 1'b0;
        chk_quiet("late_resp");
        goto(21);
        chk("rerelease_not_early", command_valid_out, 0);
        goto(22);
        chk("rerelease_cmd_valid", command_valid_out, 1);
        chk("rerelease_cmd_chan", command_channel_out, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Schedules conversions on the MAX10 built-in ADC sequencer core (Avalon-ST command/response) for the transceiver. A periodic high-priority audio channel (mic) is interleaved with two low-rate auxiliary channels (e.g. supply voltage, PA temperature). Results are routed to an audio sample strobe and two stb/ack registers readable by the control CPU. Sits between the `adc` core and the transceiver/CPU logic, replacing the tied-off `command_valid`.

## Interface
Parameters:
- AUDIO_DIVIDE, 1000 — clk cycles per audio conversion request (10 kHz at 10 MHz); ≥ 4
- AUX_DIVIDE, 100000 — clk cycles per auxiliary request pair; ≥ 4
- TIMEOUT, 255 — max cycles waiting for a response; 8-bit counter

Ports:
- clk  in  1  ADC clock domain (clk_10)
- rst  in  1  synchronous, active-high reset
- audio_channel_in / aux0_channel_in / aux1_channel_in  in  5 each  channel numbers, sampled at issue
- command_valid_out  out  1  command request
- command_channel_out  out  5  channel of command
- command_startofpacket_out, command_endofpacket_out  out  1 each  both equal command_valid_out
- command_ready_in  in  1  core accepts command
- response_valid_in  in  1;  response_channel_in  in  5;  response_data_in  in  12
- audio_out  out  12;  audio_stb_out  out  1  one-cycle pulse, no backpressure
- aux0_out, aux1_out  out  12 each;  aux0_stb_out, aux1_stb_out  out  1;  aux0_ack_in, aux1_ack_in  in  1
- overrun_out  out  1  sticky: audio request lost
- timeout_out  out  1  sticky: response never arrived
- clear_errors_in  in  1  clears both sticky flags

## Operation
- Two free-running dividers: audio_tick every AUDIO_DIVIDE cycles, aux_tick every AUX_DIVIDE cycles; first tick AUDIO_DIVIDE/AUX_DIVIDE cycles after reset release.
- Pending flags: pend_next = (pend & ~issued) | tick. aux_tick sets aux0_pend and aux1_pend.
- overrun_out set when audio_tick && audio_pend && !audio_issued. Aux re-tick while pending: no flag.
- FSM IDLE → ISSUE → WAIT → IDLE:
  - IDLE: fixed priority audio > aux0 > aux1; on any pending, latch channel + target id → ISSUE.
  - ISSUE: command_valid_out=1; on command_valid_out && command_ready_in, clear that pending flag → WAIT.
  - WAIT: accept only response_valid_in with response_channel_in == latched channel; mismatches ignored. Accept → write target → IDLE. Counter reaching TIMEOUT → set timeout_out, → IDLE, no output.
- One command outstanding at a time.
- Audio target: audio_out <= data, audio_stb_out pulses 1 cycle.
- Aux target: auxN_out <= data, auxN_stb_out <= 1. Cleared on stb && ack. New data overwrites an unacked value; stb stays 1. Write and ack in the same cycle → stb stays 1.
- clear_errors_in clears flags; a set event in the same cycle wins.
- Reset values: all outputs 0; FSM IDLE; pending flags, dividers and timeout counter 0. Responses arriving after reset, outside WAIT, are ignored.

## Timing
- Tick at cycle N with FSM in IDLE → command_valid_out high at N+2 (N+1 latches selection).
- command_valid_out holds until ready; channel stable while valid.
- Matching response at cycle M → audio_stb_out / auxN_stb_out high at M+1, FSM IDLE at M+1, next command_valid_out at M+2 earliest.
- Timeout measured from the WAIT entry cycle; flag set on the cycle the counter equals TIMEOUT.
- Reset takes effect at the next clk edge regardless of state, including mid-handshake.

## Structure
- Shared header `adc_sequencer_defs.vh`: CHANNEL_WIDTH=5, DATA_WIDTH=12, FSM state encodings, target ids (AUDIO=0, AUX0=1, AUX1=2).
- One sub-module `rate_divider` (parameter DIVIDE; ports clk, rst, tick_out), instantiated twice.

## Test plan
- AUDIO_DIVIDE=20, ready always 1, core model responds 5 cycles after command → command_valid_out every 20 cycles, channel=audio_channel_in, audio_stb_out once per request with returned data (e.g. 12'hA5C).
- Tick audio and aux together, all channels distinct (1,2,3) → command order 1, 2, 3; aux0_out/aux1_out hold data; stbs stay high until ack pulses, then drop next cycle.
- Model never responds, TIMEOUT=16 → timeout_out set 16 cycles after WAIT entry; FSM issues next pending command; clear_errors_in clears it.
- command_ready_in low 50 cycles with AUDIO_DIVIDE=20 → overrun_out set on second tick; command_valid_out held and channel stable throughout.
- Response with wrong channel (7 instead of 1) then correct → first ignored, only 12'h123 of the correct one on audio_out.
- rst asserted during WAIT, response arrives next cycle → no strobes, all outputs 0, first command AUDIO_DIVIDE+2 cycles after release.
